shared_mem_responder: RTL and testbench
=======================================

# shared_mem_responder

Memory-side responder for the two-cache shared bus: accepts read and write-back requests from cache A and cache B, arbitrates between them, serves them from a single word-addressed backing memory, and returns completion handshakes. It is the bus end of the cache-to-memory interface driven by each cache's `rwToMem`/`addrToMem`/`datatomem` outputs. It is the single point of serialisation for all memory traffic between the two processor/cache pairs.

## Interface
- `ADDRWIDTH`, 8, word address width; memory depth is 2^ADDRWIDTH words
- `WORDWIDTH`, 32, data word width
- `IOSTATEWIDTH`, 2, request-code width; 2'b00 IDLE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved (treated as IDLE)
- `MEM_LAT`, 2, service cycles per access (≥1)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `rwFromCacheA` / `rwFromCacheB`  in  IOSTATEWIDTH  request code per port
- `addrFromCacheA` / `addrFromCacheB`  in  ADDRWIDTH  word address
- `dataFromCacheA` / `dataFromCacheB`  in  WORDWIDTH  write-back data
- `dataToCacheA` / `dataToCacheB`  out  WORDWIDTH  read data
- `rdEnToCacheA` / `rdEnToCacheB`  out  1  one-cycle read-complete pulse
- `wbDoneToCacheA` / `wbDoneToCacheB`  out  1  one-cycle write-complete pulse

## Operation
- Memory: 2^ADDRWIDTH × WORDWIDTH array; contents not cleared by reset.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: sample both rw codes. No valid request → stay. One valid → grant it. Both valid → grant the port indicated by priority pointer. On grant latch port id, op, addr, data; load counter with MEM_LAT-1; go BUSY.
  - BUSY: decrement counter; at 0 go DONE.
  - DONE: READ → `dataToCacheX` ← mem[addr], assert `rdEnToCacheX`. WRITE → mem[addr] ← latched data, assert `wbDoneToCacheX`. Toggle priority pointer to the other port. Go IDLE.
- Priority pointer: reset to A; flips after every completed access regardless of contention → round-robin.
- Requester rule: cache holds rw/addr/data stable until its done pulse, then drives IDLE for at least one cycle. The responder ignores the just-served port in the IDLE cycle immediately following its DONE, so a stale code is never re-granted.
- Latched request is authoritative: changes on the cache inputs after grant do not affect the access.
- Ungranted port waits with no response; its request is served next (pointer favours it).
- Reserved code 2'b11 never granted.
- `dataToCacheX` holds its last read value until the next read completion on that port; writes and the other port's traffic do not disturb it.

## Timing
- Reset values: all `dataToCache*` = 0, all `rdEn*`/`wbDone*` = 0, FSM = IDLE, pointer = A, counter = 0.
- Request visible at edge k (FSM IDLE) → grant at k; done pulse high during cycle after edge k+MEM_LAT+1 (i.e. MEM_LAT+1 cycles of latency); read data valid in the same cycle as `rdEn`, stable thereafter.
- Back-to-back: next grant earliest at the edge ending DONE+1 (IDLE cycle); throughput one access per MEM_LAT+2 cycles.
- Done pulses exactly one cycle; never both ports in the same cycle; never rdEn and wbDone together.
- Reset asserted mid-access: at that edge FSM→IDLE, latched access discarded, no memory write, outputs to reset values; an access in DONE at the reset edge does not commit.
- Same-address write on one port followed by read on the other: serialised; read returns the written value.

## Test plan
- Reset: hold reset 2 cycles with both ports requesting → all outputs 0, no grant until the cycle after reset deasserts.
- Single write/read, MEM_LAT=2: A WRITE addr 0x10 data 0xDEADBEEF → `wbDoneToCacheA` pulse exactly 3 cycles after request edge; A READ 0x10 → `rdEnToCacheA` 3 cycles later with `dataToCacheA`=0xDEADBEEF.
- Contention: A READ 0x01 and B WRITE 0x01 data 0x5 same edge, pointer=A → A served first (returns old value), then B; a second simultaneous pair is served B first.
- Cross-port coherence: B WRITE 0x20 = 0x1234, then A READ 0x20 → 0x1234; `dataToCacheB` unchanged by A's read.
- Reset mid-BUSY: A WRITE 0x30 = 0xFF, assert reset in BUSY → no wbDone, subsequent READ 0x30 returns pre-test value.
- Stale request: A keeps READ asserted one cycle past `rdEnToCacheA` → exactly one pulse; B requesting concurrently is granted in the following IDLE.

Source files
------------

// File: rtl/shared_mem_responder.sv
// -----------------------------------------------------------------------------
// shared_mem_responder
//
// Memory-side end of the two-cache shared bus. Cache A and cache B each present
// a request code (IDLE / READ / WRITE), a word address and write-back data.
// The responder arbitrates between the two ports with a round-robin pointer,
// performs one access at a time against a single word-addressed backing
// memory, and answers the granted port with a one-cycle completion pulse
// (rdEnToCacheX with read data, or wbDoneToCacheX for a write-back).
// All memory traffic between the two processor/cache pairs is serialised here.
//
// Parameters
//   ADDRWIDTH     word address width; memory depth is 2**ADDRWIDTH words
//   WORDWIDTH     data word width
//   IOSTATEWIDTH  request-code width (00 IDLE, 01 READ, 10 WRITE, 11 ignored)
//   MEM_LAT       service cycles per access (>= 1)
//
// Ports
//   clk                           single clock, rising edge
//   reset                         synchronous, active-high
//   rwFromCacheA/B                request code per port
//   addrFromCacheA/B              word address per port
//   dataFromCacheA/B              write-back data per port
//   dataToCacheA/B                read data, held until the next read on that port
//   rdEnToCacheA/B                one-cycle read-complete pulse
//   wbDoneToCacheA/B              one-cycle write-complete pulse
//
// Timing: a request sampled at edge k while idle is granted at k; the done
// pulse is high during the cycle after edge k+MEM_LAT+1. One access completes
// every MEM_LAT+2 cycles at best.
// -----------------------------------------------------------------------------
module shared_mem_responder #(
  parameter int ADDRWIDTH    = 8,
  parameter int WORDWIDTH    = 32,
  parameter int IOSTATEWIDTH = 2,
  parameter int MEM_LAT      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwFromCacheA,
  input  logic [IOSTATEWIDTH-1:0] rwFromCacheB,
  input  logic [ADDRWIDTH-1:0]    addrFromCacheA,
  input  logic [ADDRWIDTH-1:0]    addrFromCacheB,
  input  logic [WORDWIDTH-1:0]    dataFromCacheA,
  input  logic [WORDWIDTH-1:0]    dataFromCacheB,
  output logic [WORDWIDTH-1:0]    dataToCacheA,
  output logic [WORDWIDTH-1:0]    dataToCacheB,
  output logic                    rdEnToCacheA,
  output logic                    rdEnToCacheB,
  output logic                    wbDoneToCacheA,
  output logic                    wbDoneToCacheB
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  // Counter only has to hold MEM_LAT-1.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  localparam logic [IOSTATEWIDTH-1:0] RW_READ  = IOSTATEWIDTH'(1);
  localparam logic [IOSTATEWIDTH-1:0] RW_WRITE = IOSTATEWIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Port 0 is cache A, port 1 is cache B throughout.
  logic [IOSTATEWIDTH-1:0] rw_in   [2];
  logic [ADDRWIDTH-1:0]    addr_in [2];
  logic [WORDWIDTH-1:0]    data_in [2];

  assign rw_in[0]   = rwFromCacheA;
  assign rw_in[1]   = rwFromCacheB;
  assign addr_in[0] = addrFromCacheA;
  assign addr_in[1] = addrFromCacheB;
  assign data_in[0] = dataFromCacheA;
  assign data_in[1] = dataFromCacheB;

  // Architectural state
  state_t               state_reg;
  logic                 prio_reg;         // 0: A wins a tie, 1: B wins a tie
  logic [CNT_W-1:0]     cnt_reg;
  logic                 grant_port_reg;   // port owning the access in flight
  logic                 grant_write_reg;  // 1: write-back, 0: read
  logic [ADDRWIDTH-1:0] addr_reg;
  logic [WORDWIDTH-1:0] data_reg;

  // The port just answered may still show its old request code in the first
  // idle cycle after its pulse; it is masked for exactly that cycle.
  logic                 block_valid_reg;
  logic                 block_port_reg;

  // Registered outputs
  logic [WORDWIDTH-1:0] data_out_reg [2];
  logic [1:0]           rd_en_reg;
  logic [1:0]           wb_done_reg;

  // Backing memory and its registered read port
  logic [WORDWIDTH-1:0] mem [0:DEPTH-1];
  logic [WORDWIDTH-1:0] rd_word_reg;
  logic                 mem_we;

  // Request decode
  logic [1:0] req_valid;
  logic [1:0] req_write;
  logic       grant_any;
  logic       grant_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Reserved code 11 is neither READ nor WRITE, so it never becomes valid.
      assign req_valid[gi] = ((rw_in[gi] == RW_READ) || (rw_in[gi] == RW_WRITE)) &&
                             !(block_valid_reg && (block_port_reg == 1'(gi)));
      assign req_write[gi] = (rw_in[gi] == RW_WRITE);
    end
  endgenerate

  assign grant_any = |req_valid;

  // Pointer only matters when both ports are valid in the same cycle.
  always_comb begin
    grant_sel = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant_sel = prio_reg;
    end else if (req_valid[1]) begin
      grant_sel = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      prio_reg        <= 1'b0;
      cnt_reg         <= '0;
      grant_port_reg  <= 1'b0;
      grant_write_reg <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
      block_valid_reg <= 1'b0;
      block_port_reg  <= 1'b0;
      data_out_reg[0] <= '0;
      data_out_reg[1] <= '0;
      rd_en_reg       <= '0;
      wb_done_reg     <= '0;
    end else begin
      // Pulses and the stale-request mask each last a single cycle.
      rd_en_reg       <= '0;
      wb_done_reg     <= '0;
      block_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            // Snapshot the request; later changes on the inputs are ignored.
            grant_port_reg  <= grant_sel;
            grant_write_reg <= req_write[grant_sel];
            addr_reg        <= addr_in[grant_sel];
            data_reg        <= data_in[grant_sel];
            cnt_reg         <= CNT_LOAD;
            state_reg       <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_DONE: begin
          if (grant_write_reg) begin
            wb_done_reg[grant_port_reg] <= 1'b1;
          end else begin
            rd_en_reg[grant_port_reg]    <= 1'b1;
            data_out_reg[grant_port_reg] <= rd_word_reg;
          end
          // Round-robin: flips after every completed access.
          prio_reg        <= ~prio_reg;
          block_valid_reg <= 1'b1;
          block_port_reg  <= grant_port_reg;
          state_reg       <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Backing memory. Contents survive reset. The write commits on the DONE edge
  // unless reset is sampled on that same edge. The read port tracks the
  // latched address every cycle; addr_reg is stable from grant to DONE and no
  // other write can land in between, so rd_word_reg already holds the word
  // when the DONE edge copies it to the requesting port.
  // ---------------------------------------------------------------------------
  assign mem_we = (state_reg == ST_DONE) && grant_write_reg && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_reg] <= data_reg;
    end
    rd_word_reg <= mem[addr_reg];
  end

  assign dataToCacheA   = data_out_reg[0];
  assign dataToCacheB   = data_out_reg[1];
  assign rdEnToCacheA   = rd_en_reg[0];
  assign rdEnToCacheB   = rd_en_reg[1];
  assign wbDoneToCacheA = wb_done_reg[0];
  assign wbDoneToCacheB = wb_done_reg[1];

endmodule

// File: tb/tb_shared_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_responder
//
// Directed steps followed by a randomized phase. Expected results come from a
// transaction-level model: an array standing in for memory, the last read word
// per port, and a round-robin pointer that flips on every completed access.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shared_mem_responder;

  localparam int AW  = 8;
  localparam int WW  = 32;
  localparam int SW  = 2;
  localparam int LAT = 2;
  // Falling edges from the one that drives a request (FSM idle) to the one
  // that first sees its done pulse: grant edge + LAT busy edges + DONE edge.
  localparam int DONE_WAIT = LAT + 2;

  localparam logic [SW-1:0] C_IDLE = 2'b00;
  localparam logic [SW-1:0] C_RD   = 2'b01;
  localparam logic [SW-1:0] C_WR   = 2'b10;
  localparam logic [SW-1:0] C_RSV  = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] rw    [2];
  logic [AW-1:0] addr  [2];
  logic [WW-1:0] wdata [2];
  logic [WW-1:0] data_a, data_b;
  logic          rd_a, rd_b, wb_a, wb_b;

  always #5 clk = ~clk;

  shared_mem_responder #(
    .ADDRWIDTH(AW), .WORDWIDTH(WW), .IOSTATEWIDTH(SW), .MEM_LAT(LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rwFromCacheA   (rw[0]),
    .rwFromCacheB   (rw[1]),
    .addrFromCacheA (addr[0]),
    .addrFromCacheB (addr[1]),
    .dataFromCacheA (wdata[0]),
    .dataFromCacheB (wdata[1]),
    .dataToCacheA   (data_a),
    .dataToCacheB   (data_b),
    .rdEnToCacheA   (rd_a),
    .rdEnToCacheB   (rd_b),
    .wbDoneToCacheA (wb_a),
    .wbDoneToCacheB (wb_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model
  logic [WW-1:0] model_mem   [256];
  bit            model_valid [256];
  logic [WW-1:0] model_rdata [2];
  int            model_ptr;

  function automatic logic get_rd(input int p);
    return (p == 0) ? rd_a : rd_b;
  endfunction

  function automatic logic get_wb(input int p);
    return (p == 0) ? wb_a : wb_b;
  endfunction

  function automatic logic [WW-1:0] get_data(input int p);
    return (p == 0) ? data_a : data_b;
  endfunction

  function automatic int pulse_count();
    return int'(rd_a) + int'(rd_b) + int'(wb_a) + int'(wb_b);
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " dataA"}, data_a, '0);
    check({tag, " dataB"}, data_b, '0);
    check({tag, " pulses"}, 32'(pulse_count()), '0);
  endtask

  // Wait for the done pulse of the request currently driven on port p and
  // compare it with the model; then retire it in the model.
  task automatic serve(input int p, input int exp_cyc, input bit hold, input string tag);
    int            cyc;
    bit            seen;
    bit            is_wr;
    int            a;
    int            q;
    logic [WW-1:0] exp_rd;
    cyc    = 0;
    seen   = 1'b0;
    q      = 1 - p;
    is_wr  = (rw[p] == C_WR);
    a      = int'(addr[p]);
    exp_rd = is_wr ? model_rdata[p] : model_mem[a];
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      check({tag, " other port quiet"}, {30'd0, get_rd(q), get_wb(q)}, '0);
      if (get_rd(p) || get_wb(p)) seen = 1'b1;
    end
    check({tag, " pulse seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " rdEn"}, 32'(get_rd(p)), 32'(!is_wr));
    check({tag, " wbDone"}, 32'(get_wb(p)), 32'(is_wr));
    check({tag, " data"}, get_data(p), exp_rd);
    check({tag, " other data held"}, get_data(q), model_rdata[q]);
    if (is_wr) begin
      model_mem[a]   = wdata[p];
      model_valid[a] = 1'b1;
    end else begin
      model_rdata[p] = exp_rd;
    end
    model_ptr = 1 - model_ptr;
    if (!hold) rw[p] = C_IDLE;
  endtask

  task automatic single(input int p, input logic [SW-1:0] op, input logic [AW-1:0] a,
                        input logic [WW-1:0] d, input string tag);
    @(negedge clk);
    rw[p] = op; addr[p] = a; wdata[p] = d;
    serve(p, DONE_WAIT, 1'b0, tag);
  endtask

  task automatic pair(input logic [SW-1:0] op0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                      input logic [SW-1:0] op1, input logic [AW-1:0] a1, input logic [WW-1:0] d1,
                      input string tag);
    int first;
    @(negedge clk);
    rw[0] = op0; addr[0] = a0; wdata[0] = d0;
    rw[1] = op1; addr[1] = a1; wdata[1] = d1;
    first = model_ptr;
    serve(first, DONE_WAIT, 1'b0, {tag, " first"});
    serve(1 - first, DONE_WAIT, 1'b0, {tag, " second"});
  endtask

  // Start a write on A and assert reset 'at' falling edges later.
  task automatic reset_mid(input int at, input string tag);
    int pulses;
    pulses = 0;
    @(negedge clk);
    rw[0] = C_WR; addr[0] = 8'h30; wdata[0] = 32'h0000_00FF;
    repeat (at) begin
      @(negedge clk);
      pulses += pulse_count();
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_state({tag, " in reset"});
    reset = 1'b0;
    rw[0] = C_IDLE;
    repeat (DONE_WAIT + 2) begin
      @(negedge clk);
      pulses += pulse_count();
    end
    check({tag, " no pulse"}, 32'(pulses), '0);
    model_ptr      = 0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            pulses;
    int            kind;
    logic [AW-1:0] ra0, ra1;
    logic [SW-1:0] op0, op1;

    model_ptr      = 0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;

    // Reset held two cycles with both ports requesting.
    reset = 1'b1;
    rw[0] = C_WR; addr[0] = 8'h00; wdata[0] = 32'hA0A0_0001;
    rw[1] = C_WR; addr[1] = 8'h02; wdata[1] = 32'hB0B0_0002;
    repeat (2) begin
      @(negedge clk);
      check_reset_state("reset");
    end
    reset = 1'b0;
    serve(0, DONE_WAIT, 1'b0, "post-reset A");
    serve(1, DONE_WAIT, 1'b0, "post-reset B");

    // Single write then read on A.
    single(0, C_WR, 8'h10, 32'hDEAD_BEEF, "A write 0x10");
    single(0, C_RD, 8'h10, '0, "A read 0x10");

    // Cross-port coherence; B reads first so its data output is non-zero.
    single(1, C_WR, 8'h20, 32'h0000_1234, "B write 0x20");
    single(1, C_RD, 8'h10, '0, "B read 0x10");
    single(0, C_RD, 8'h20, '0, "A read 0x20");

    // Contention with pointer on A, then with pointer on B.
    single(0, C_WR, 8'h01, 32'h1111_1111, "A init 0x01");
    if (model_ptr != 0) single(1, C_RD, 8'h10, '0, "align to A");
    pair(C_RD, 8'h01, '0, C_WR, 8'h01, 32'h0000_0005, "contend ptrA");
    if (model_ptr != 1) single(0, C_RD, 8'h01, '0, "align to B");
    pair(C_WR, 8'h03, 32'h0000_0033, C_RD, 8'h01, '0, "contend ptrB");

    // Reset during BUSY and during DONE: no commit, no pulse.
    single(0, C_WR, 8'h30, 32'h0000_00AB, "A pretest 0x30");
    reset_mid(LAT, "reset in BUSY");
    single(0, C_RD, 8'h30, '0, "A read 0x30 after BUSY reset");
    reset_mid(LAT + 1, "reset in DONE");
    single(0, C_RD, 8'h30, '0, "A read 0x30 after DONE reset");

    // Reserved code is never granted, even against the pointer.
    @(negedge clk);
    rw[0] = C_RSV; addr[0] = 8'h30; wdata[0] = 32'hFFFF_FFFF;
    pulses = 0;
    repeat (DONE_WAIT + 2) begin
      @(negedge clk);
      pulses += pulse_count();
    end
    check("reserved quiet", 32'(pulses), '0);
    rw[1] = C_WR; addr[1] = 8'h31; wdata[1] = 32'h0000_0031;
    serve(1, DONE_WAIT, 1'b0, "reserved vs B write");
    rw[0] = C_IDLE;

    // Stale request: A holds READ two cycles past its pulse while B waits.
    if (model_ptr != 0) single(1, C_RD, 8'h10, '0, "align stale");
    @(negedge clk);
    rw[0] = C_RD; addr[0] = 8'h20;
    rw[1] = C_RD; addr[1] = 8'h10;
    serve(0, DONE_WAIT, 1'b1, "stale A");
    @(negedge clk);
    @(negedge clk);
    rw[0] = C_IDLE;
    serve(1, DONE_WAIT - 2, 1'b0, "stale B");
    pulses = 0;
    repeat (DONE_WAIT + 2) begin
      @(negedge clk);
      pulses += pulse_count();
    end
    check("stale no repeat", 32'(pulses), '0);

    // Randomized traffic over a 16-word window.
    for (int it = 0; it < 40; it++) begin
      ra0  = 8'h40 + 8'($urandom_range(0, 15));
      ra1  = 8'h40 + 8'($urandom_range(0, 15));
      op0  = ($urandom_range(0, 1) == 1) ? C_WR : C_RD;
      op1  = ($urandom_range(0, 1) == 1) ? C_WR : C_RD;
      if (!model_valid[int'(ra0)]) op0 = C_WR;
      if (!model_valid[int'(ra1)]) op1 = C_WR;
      kind = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (kind == 0) begin
        single(0, op0, ra0, $urandom(), "rand A");
      end else if (kind == 1) begin
        single(1, op1, ra1, $urandom(), "rand B");
      end else begin
        pair(op0, ra0, $urandom(), op1, ra1, $urandom(), "rand pair");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
